// File: rtl/menu_cursor_grid_pkg.sv
// Shared types and limits for the battle-menu cursor.
// Package menu_pkg: dir_t button decode, screen limits, index width helper.
package menu_pkg;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_L,
        DIR_R,
        DIR_U,
        DIR_D,
        DIR_SEL
    } dir_t;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/menu_cursor_grid_if.sv
// Button/cursor bundle between the menu cursor and its surroundings.
// master: drives en/left/right/up/down/enter, reads sel/x/y/command.
// slave : the cursor grid, reads buttons, drives sel/x/y/command.
interface menu_cursor_grid_if #(
    parameter int ITEMS = 8,
    parameter int IW    = 3
);
    logic             en;
    logic             left;
    logic             right;
    logic             up;
    logic             down;
    logic             enter;
    logic [IW-1:0]    sel;
    logic [9:0]       x;
    logic [8:0]       y;
    logic [ITEMS-1:0] command;

    modport master (
        output en, left, right, up, down, enter,
        input  sel, x, y, command
    );

    modport slave (
        input  en, left, right, up, down, enter,
        output sel, x, y, command
    );
endinterface

// File: rtl/menu_cursor_grid_btn_event.sv
// Button edge detector: turns single-button presses into dir_t events.
// Ports: clk, rst_n (sync, active-low), en, btn {enter,down,up,right,left},
// dir/valid (valid is a 1-cycle pulse). MENU_AUTOREPEAT_EN adds repeat.
module menu_btn_event
    import menu_pkg::*;
#(
    parameter int RPT_DLY  = 25000000,
    parameter int RPT_RATE = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [4:0] btn,
    output dir_t       dir,
    output logic       valid
);
    logic [4:0] hist_q, hist_d;
    logic       onehot;
    logic       press;

    if (RPT_RATE < 1 || RPT_RATE > RPT_DLY) begin : g_rpt_err
        $error("menu_btn_event: need 1 <= RPT_RATE <= RPT_DLY");
    end

    always_comb begin
        hist_d = btn;
        onehot = (btn != 5'd0) && ((btn & (btn - 5'd1)) == 5'd0);
        // A press needs a new rising edge and no other button held.
        press  = en && onehot && ((btn & ~hist_q) != 5'd0);
        case (btn)
            5'b00001: dir = DIR_L;
            5'b00010: dir = DIR_R;
            5'b00100: dir = DIR_U;
            5'b01000: dir = DIR_D;
            5'b10000: dir = DIR_SEL;
            default:  dir = DIR_NONE;
        endcase
    end

    // History resets to all-ones so a button held through reset
    // must be released and pressed again before it acts.
    always_ff @(posedge clk) begin
        if (!rst_n) hist_q <= '1;
        else        hist_q <= hist_d;
    end

`ifdef MENU_AUTOREPEAT_EN
    localparam int CNTW = $clog2(RPT_DLY + 1);

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            held;
    logic            rpt;

    always_comb begin
        // cnt_q != 0 only after a genuine press of the held direction.
        held  = en && onehot && !btn[4] && (btn == hist_q)
                && (cnt_q != '0);
        rpt   = held && (cnt_q == CNTW'(RPT_DLY));
        cnt_d = '0;
        if (press && !btn[4])
            cnt_d = CNTW'(1);
        else if (rpt)
            cnt_d = CNTW'(RPT_DLY - RPT_RATE + 1);
        else if (held)
            cnt_d = cnt_q + CNTW'(1);
        valid = press || rpt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign valid = press;
`endif

endmodule

// File: rtl/menu_cursor_grid.sv
// COLS x ROWS menu cursor: wrap-around moves, pixel origin, command pulse.
// Ports: clk, rst_n (sync, active-low), bus (slave modport: buttons in,
// sel/x/y/command out). Optional MENU_AUTOREPEAT_EN enables held repeat.
module menu_cursor_grid
    import menu_pkg::*;
#(
    parameter int COLS     = 4,
    parameter int ROWS     = 2,
    parameter int X0       = 8,
    parameter int Y0       = 22,
    parameter int DX       = 40,
    parameter int DY       = 40,
    parameter int RPT_DLY  = 25000000,
    parameter int RPT_RATE = 10000000
) (
    input  logic              clk,
    input  logic              rst_n,
    menu_cursor_grid_if.slave bus
);
    localparam int ITEMS = COLS * ROWS;
    localparam int IW    = (ITEMS > 1) ? idx_w(ITEMS) : 1;
    localparam int CW    = (COLS > 1) ? idx_w(COLS) : 1;
    localparam int RW    = (ROWS > 1) ? idx_w(ROWS) : 1;

    if (X0 + (COLS - 1) * DX >= H_RES ||
        Y0 + (ROWS - 1) * DY >= V_RES) begin : g_range_err
        $error("menu_cursor_grid: cursor grid exceeds the screen");
    end

    dir_t             dir;
    logic             valid;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic [IW-1:0]    sel_q, sel_d;
    logic [9:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic [ITEMS-1:0] cmd_q, cmd_d;

    menu_btn_event #(
        .RPT_DLY  (RPT_DLY),
        .RPT_RATE (RPT_RATE)
    ) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .btn   ({bus.enter, bus.down, bus.up, bus.right, bus.left}),
        .dir   (dir),
        .valid (valid)
    );

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        cmd_d = '0;
        if (valid) begin
            unique case (dir)
                DIR_R: begin
                    // Linear step: leaving the last column wraps a row.
                    if (col_q == CW'(COLS - 1)) begin
                        col_d = '0;
                        row_d = (row_q == RW'(ROWS - 1)) ? '0
                                : row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
                DIR_L: begin
                    if (col_q == '0) begin
                        col_d = CW'(COLS - 1);
                        row_d = (row_q == '0) ? RW'(ROWS - 1)
                                : row_q - RW'(1);
                    end else begin
                        col_d = col_q - CW'(1);
                    end
                end
                DIR_U: row_d = (row_q == '0) ? RW'(ROWS - 1)
                               : row_q - RW'(1);
                DIR_D: row_d = (row_q == RW'(ROWS - 1)) ? '0
                               : row_q + RW'(1);
                DIR_SEL: cmd_d[sel_q] = 1'b1;
                default: ;
            endcase
        end
        sel_d = IW'(int'(row_d) * COLS + int'(col_d));
        x_d   = 10'(X0 + int'(col_d) * DX);
        y_d   = 9'(Y0 + int'(row_d) * DY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            sel_q <= '0;
            x_q   <= 10'(X0);
            y_q   <= 9'(Y0);
            cmd_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            sel_q <= sel_d;
            x_q   <= x_d;
            y_q   <= y_d;
            cmd_q <= cmd_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.x       = x_q;
    assign bus.y       = y_q;
    assign bus.command = cmd_q;

endmodule

// File: tb/tb_menu_cursor_grid.sv
// Scoreboard bench for menu_cursor_grid with a grid-level reference model.
// Directed scenarios followed by randomized button traffic.
module tb_menu_cursor_grid;
    localparam int COLS  = 4;
    localparam int ROWS  = 2;
    localparam int ITEMS = COLS * ROWS;
    localparam int X0    = 8;
    localparam int Y0    = 22;
    localparam int DX    = 40;
    localparam int DY    = 40;
    localparam int RD    = 8;
    localparam int RR    = 4;
`ifdef MENU_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    localparam logic [4:0] B0 = 5'b00000;
    localparam logic [4:0] BL = 5'b00001;
    localparam logic [4:0] BR = 5'b00010;
    localparam logic [4:0] BU = 5'b00100;
    localparam logic [4:0] BD = 5'b01000;
    localparam logic [4:0] BE = 5'b10000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    menu_cursor_grid_if #(.ITEMS(ITEMS), .IW(3)) bus();

    menu_cursor_grid #(
        .COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0), .DX(DX), .DY(DY),
        .RPT_DLY(RD), .RPT_RATE(RR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int sel;
        int x;
        int y;
        int cmd;
    } exp_t;

    exp_t q[$];
    int vectors     = 0;
    int miscompares = 0;

    int         m_sel  = 0;
    logic [4:0] m_prev = 5'h1f;
    int         m_held = -1;

    function automatic exp_t view(input int s, input int c);
        exp_t e;
        e.sel = s;
        e.x   = X0 + (s % COLS) * DX;
        e.y   = Y0 + (s / COLS) * DY;
        e.cmd = c;
        return e;
    endfunction

    // Reference: selection as a plain index into ITEMS, rows by division.
    task automatic model(input logic [4:0] b, input bit e, input bit r);
        int   ones;
        bit   fire;
        int   cmd;
        int   row;
        int   col;
        if (!r) begin
            m_sel  = 0;
            m_prev = 5'h1f;
            m_held = -1;
            q.push_back(view(0, 0));
            return;
        end
        ones = $countones(b);
        fire = 1'b0;
        cmd  = 0;
        if (e && ones == 1 && (b & ~m_prev) != 5'd0) begin
            fire   = 1'b1;
            m_held = (b == BE) ? -1 : 0;
        end else if (AR && e && ones == 1 && b != BE && b == m_prev
                     && m_held >= 0) begin
            m_held++;
            fire = (m_held >= RD) && ((m_held - RD) % RR == 0);
        end else begin
            m_held = -1;
        end
        if (fire) begin
            row = m_sel / COLS;
            col = m_sel % COLS;
            case (b)
                BL: m_sel = (m_sel + ITEMS - 1) % ITEMS;
                BR: m_sel = (m_sel + 1) % ITEMS;
                BU: m_sel = ((row + ROWS - 1) % ROWS) * COLS + col;
                BD: m_sel = ((row + 1) % ROWS) * COLS + col;
                BE: cmd = 1 << m_sel;
                default: ;
            endcase
        end
        m_prev = b;
        q.push_back(view(m_sel, cmd));
    endtask

    task automatic step(input logic [4:0] b, input bit e = 1'b1,
                        input bit r = 1'b1);
        @(negedge clk);
        bus.left  = b[0];
        bus.right = b[1];
        bus.up    = b[2];
        bus.down  = b[3];
        bus.enter = b[4];
        bus.en    = e;
        rst_n     = r;
        model(b, e, r);
    endtask

    task automatic spot(input string name, input int s, input int xx,
                        input int yy, input int c);
        logic [2:0] es;
        logic [9:0] ex;
        logic [8:0] ey;
        logic [7:0] ec;
        es = s[2:0];
        ex = xx[9:0];
        ey = yy[8:0];
        ec = c[7:0];
        vectors++;
        if (bus.sel !== es || bus.x !== ex || bus.y !== ey ||
            bus.command !== ec) begin
            miscompares++;
            $display("FAIL %s: got sel=%0d x=%0d y=%0d cmd=%b, want sel=%0d x=%0d y=%0d cmd=%b",
                     name, bus.sel, bus.x, bus.y, bus.command,
                     es, ex, ey, ec);
        end
    endtask

    exp_t ex_m;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                ex_m = q.pop_front();
                vectors++;
                if (bus.sel !== ex_m.sel[2:0] || bus.x !== ex_m.x[9:0] ||
                    bus.y !== ex_m.y[8:0] ||
                    bus.command !== ex_m.cmd[7:0]) begin
                    miscompares++;
                    $display("FAIL scoreboard t=%0t: got sel=%0d x=%0d y=%0d cmd=%b, want sel=%0d x=%0d y=%0d cmd=%b",
                             $time, bus.sel, bus.x, bus.y, bus.command,
                             ex_m.sel, ex_m.x, ex_m.y, ex_m.cmd[7:0]);
                end
            end
        end
    end

    logic [4:0] rb;
    int         len;
    int         pick;
    bit         re;
    bit         rr;

    initial begin
        bus.left  = 1'b0;
        bus.right = 1'b0;
        bus.up    = 1'b0;
        bus.down  = 1'b0;
        bus.enter = 1'b0;
        bus.en    = 1'b1;

        step(B0, 1, 0);
        step(B0, 1, 0);
        step(B0);
        spot("reset", 0, 8, 22, 0);
        step(BR); step(B0);
        spot("right", 1, 48, 22, 0);
        step(BL); step(B0);
        step(BL); step(B0);
        spot("left_wrap", 7, 128, 62, 0);
        step(BR); step(B0);
        spot("right_wrap", 0, 8, 22, 0);
        step(BR); step(B0);
        step(BU); step(B0);
        spot("up_wrap", 5, 48, 62, 0);
        step(BE); step(B0);
        spot("enter_pulse", 5, 48, 62, 32);
        step(B0);
        spot("enter_one_cycle", 5, 48, 62, 0);
        step(BD); step(B0);
        spot("down_wrap", 1, 48, 22, 0);
        step(BL | BR); step(B0);
        spot("left_right_together", 1, 48, 22, 0);
        step(BU); step(BU | BE); step(B0);
        spot("enter_while_up", 5, 48, 62, 0);

        step(BR, 1, 0); step(BR, 1, 0);
        step(BR); step(BR); step(BR);
        spot("held_through_reset", 0, 8, 22, 0);
        step(B0); step(BR); step(B0);
        spot("repress_after_reset", 1, 48, 22, 0);
        step(BE, 1, 0); step(B0);
        spot("reset_mid_enter", 0, 8, 22, 0);
        step(BR, 0); step(B0, 0);
        spot("en_low", 0, 8, 22, 0);
        step(BR, 0); step(BR, 1); step(B0);
        spot("held_across_en", 0, 8, 22, 0);

        repeat (20) step(BR);
        step(B0);
`ifdef MENU_AUTOREPEAT_EN
        spot("hold_right_20", 4, 8, 62, 0);
`else
        spot("hold_right_20", 1, 48, 22, 0);
`endif

        for (int seg = 0; seg < 180; seg++) begin
            pick = $urandom_range(0, 99);
            if (pick < 20)      rb = B0;
            else if (pick < 80) rb = 5'(1 << $urandom_range(0, 4));
            else                rb = 5'($urandom_range(0, 31));
            re  = ($urandom_range(0, 9) != 0);
            rr  = ($urandom_range(0, 39) != 0);
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(8, 22)
                                              : $urandom_range(1, 4);
            for (int k = 0; k < len; k++) step(rb, re, rr);
        end

        repeat (3) step(B0);
        repeat (4) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
